// File: rtl/operand_loader_pkg.sv
// -----------------------------------------------------------------------------
// operand_loader_pkg
// Shared definitions for the serial operand loader that feeds the 8-bit AND
// stage: default widths, the FSM state encoding, and a small helper that
// sizes the per-operand bit counter.
// -----------------------------------------------------------------------------
package operand_loader_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 8;

    localparam logic [1:0] ST_LOAD_A = 2'd0;
    localparam logic [1:0] ST_LOAD_B = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    typedef enum logic [1:0] {
        S_LOAD_A = ST_LOAD_A,
        S_LOAD_B = ST_LOAD_B,
        S_HOLD   = ST_HOLD
    } state_e;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/operand_loader8_if.sv
// -----------------------------------------------------------------------------
// operand_loader8_if
// Bundles the serial input handshake and the operand output handshake of the
// loader.
//   master : the loader (drives din_ready, op_a, op_b, op_valid, busy,
//            xfer_count; receives din, din_valid, abort, op_ready)
//   slave  : the environment on the other side (serial source + consumer)
// -----------------------------------------------------------------------------
interface operand_loader8_if
    import operand_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) ();

    logic             din;
    logic             din_valid;
    logic             din_ready;
    logic             abort;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_valid;
    logic             op_ready;
    logic             busy;
    logic [CNT_W-1:0] xfer_count;

    modport master (
        input  din, din_valid, abort, op_ready,
        output din_ready, op_a, op_b, op_valid, busy, xfer_count
    );

    modport slave (
        output din, din_valid, abort, op_ready,
        input  din_ready, op_a, op_b, op_valid, busy, xfer_count
    );

endinterface

// File: rtl/operand_loader8_shift_reg_w.sv
// -----------------------------------------------------------------------------
// shift_reg_w
// WIDTH-bit serial-in shift register with enable and synchronous active-low
// reset. MSB_FIRST=1 shifts toward the MSB (new bit enters bit 0), so after
// WIDTH shifts the first bit sits in bit WIDTH-1. MSB_FIRST=0 shifts toward
// the LSB (new bit enters bit WIDTH-1), leaving the first bit in bit 0.
//   clk, rst_n : clock, synchronous active-low reset (clears to zero)
//   en_i       : shift one position this cycle
//   bit_i      : serial bit shifted in
//   q_o        : parallel contents
// -----------------------------------------------------------------------------
module shift_reg_w
    import operand_loader_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Each bit either keeps its value or takes its neighbour on the side the
    // stream comes in from; the end bit on that side takes the serial input.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_in
                assign q_d[gi] = en_i ? bit_i : q_q[gi];
            end else begin : g_mid
                assign q_d[gi] = en_i ? q_q[gi-1] : q_q[gi];
            end
        end else begin : g_lsb
            if (gi == WIDTH-1) begin : g_in
                assign q_d[gi] = en_i ? bit_i : q_q[gi];
            end else begin : g_mid
                assign q_d[gi] = en_i ? q_q[gi+1] : q_q[gi];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/operand_loader8.sv
// -----------------------------------------------------------------------------
// operand_loader8
// Deserialises a 1-bit stream into operand A then operand B, presents the pair
// to the AND stage with a valid/ready handshake, and counts completed
// transfers.
//   clk, rst_n      : clock, synchronous active-low reset
//   bus (master)    : din/din_valid/din_ready serial input, abort,
//                     op_a/op_b/op_valid/op_ready operand output,
//                     busy (partial frame) and xfer_count (handshakes mod 2^CNT_W)
// -----------------------------------------------------------------------------
module operand_loader8
    import operand_loader_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    operand_loader8_if.master  bus
);

    localparam int             BCW      = cnt_bits(WIDTH);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] xfer_q, xfer_d;
    logic             shift_a, shift_b;
    logic             accept;
    logic [WIDTH-1:0] op_a_w, op_b_w;

    assign bus.din_ready = (state_q != S_HOLD);
    assign accept        = bus.din_valid & bus.din_ready;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        xfer_d    = xfer_q;
        shift_a   = 1'b0;
        shift_b   = 1'b0;

        if (bus.abort) begin
            // A consumer that sampled the pair on this edge still counts,
            // even though the loader discards everything else.
            if (state_q == S_HOLD && bus.op_ready) begin
                xfer_d = xfer_q + CNT_W'(1);
            end
            state_d   = S_LOAD_A;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                S_LOAD_A: begin
                    if (accept) begin
                        shift_a = 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = S_LOAD_B;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BCW'(1);
                        end
                    end
                end
                S_LOAD_B: begin
                    if (accept) begin
                        shift_b = 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = S_HOLD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BCW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.op_ready) begin
                        xfer_d  = xfer_q + CNT_W'(1);
                        state_d = S_LOAD_A;
                    end
                end
                default: begin
                    state_d   = S_LOAD_A;
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_LOAD_A;
            bit_cnt_q <= '0;
            xfer_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            xfer_q    <= xfer_d;
        end
    end

    shift_reg_w #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (shift_a),
        .bit_i (bus.din),
        .q_o   (op_a_w)
    );

    shift_reg_w #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_b (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (shift_b),
        .bit_i (bus.din),
        .q_o   (op_b_w)
    );

    // op_valid is exactly "in HOLD"; state is registered, so this is clean.
    assign bus.op_valid   = (state_q == S_HOLD);
    assign bus.busy       = (state_q == S_LOAD_B) ||
                            (state_q == S_LOAD_A && bit_cnt_q != '0);
    assign bus.op_a       = op_a_w;
    assign bus.op_b       = op_b_w;
    assign bus.xfer_count = xfer_q;

endmodule

// File: tb/tb_operand_loader8.sv
// -----------------------------------------------------------------------------
// tb_operand_loader8
// Directed stimulus for operand_loader8 (MSB-first instance checked every
// cycle against a frame-level model, LSB-first instance checked by literals).
// -----------------------------------------------------------------------------
module tb_operand_loader8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    operand_loader8_if #(.WIDTH(8), .CNT_W(8)) bus  ();
    operand_loader8_if #(.WIDTH(8), .CNT_W(8)) bus2 ();

    operand_loader8 #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    operand_loader8 #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(8)) dut_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    int n_tests  = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Model: m_n counts accepted bits of the current frame (16 = pair held).
    logic [7:0] m_a, m_b;
    int         m_n;
    int         m_xfer;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_a    <= 8'h00;
            m_b    <= 8'h00;
            m_n    <= 0;
            m_xfer <= 0;
        end else if (m_n == 16) begin
            if (bus.op_ready) begin
                m_xfer <= m_xfer + 1;
                m_n    <= 0;
                $display("[TB] xfer %0d: a=%02h b=%02h and=%02h", m_xfer + 1, m_a, m_b, m_a & m_b);
            end else if (bus.abort) begin
                m_n <= 0;
            end
        end else if (bus.abort) begin
            m_n <= 0;
        end else if (bus.din_valid) begin
            if (m_n < 8) m_a <= 8'({24'd0, m_a} * 2 + {31'd0, bus.din});
            else         m_b <= 8'({24'd0, m_b} * 2 + {31'd0, bus.din});
            m_n <= m_n + 1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_din_ready", 32'(bus.din_ready), 32'(m_n != 16));
            check("cyc_op_valid",  32'(bus.op_valid),  32'(m_n == 16));
            check("cyc_busy",      32'(bus.busy),      32'(m_n != 0 && m_n != 16));
            check("cyc_op_a",      32'(bus.op_a),      32'(m_a));
            check("cyc_op_b",      32'(bus.op_b),      32'(m_b));
            check("cyc_xfer",      32'(bus.xfer_count), 32'(m_xfer % 256));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] v;
        v = {a, b};
        for (int i = 0; i < 16; i++) begin
            bus.din       = v[15-i];
            bus.din_valid = 1'b1;
            tick();
        end
        bus.din_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        bus.din = 1'b0;  bus.din_valid = 1'b0;  bus.abort = 1'b0;  bus.op_ready = 1'b0;
        bus2.din = 1'b0; bus2.din_valid = 1'b0; bus2.abort = 1'b0; bus2.op_ready = 1'b0;

        // Reset
        rst_n = 1'b0;
        tick();
        check_en = 1'b1;
        tick();
        rst_n = 1'b1;
        check("rst_op_a",      32'(bus.op_a), 32'h00);
        check("rst_op_b",      32'(bus.op_b), 32'h00);
        check("rst_op_valid",  32'(bus.op_valid), 32'd0);
        check("rst_busy",      32'(bus.busy), 32'd0);
        check("rst_xfer",      32'(bus.xfer_count), 32'd0);
        check("rst_din_ready", 32'(bus.din_ready), 32'd1);

        // Frame 33/CC, din_valid held high
        v = 16'h33CC;
        for (int i = 0; i < 16; i++) begin
            bus.din       = v[15-i];
            bus.din_valid = 1'b1;
            tick();
            if (i == 0)  check("t1_busy_after_bit1", 32'(bus.busy), 32'd1);
            if (i == 14) check("t1_valid_before_bit16", 32'(bus.op_valid), 32'd0);
            if (i == 14) check("t1_busy_bit15", 32'(bus.busy), 32'd1);
        end
        bus.din_valid = 1'b0;
        check("t1_op_valid",  32'(bus.op_valid), 32'd1);
        check("t1_op_a",      32'(bus.op_a), 32'h33);
        check("t1_op_b",      32'(bus.op_b), 32'hCC);
        check("t1_and",       32'(bus.op_a & bus.op_b), 32'h00);
        check("t1_busy_hold", 32'(bus.busy), 32'd0);
        check("t1_din_ready", 32'(bus.din_ready), 32'd0);

        // Reset during HOLD with op_ready high: the handshake must not count
        bus.op_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.op_ready = 1'b0;
        check("t5_op_a",     32'(bus.op_a), 32'h00);
        check("t5_op_b",     32'(bus.op_b), 32'h00);
        check("t5_op_valid", 32'(bus.op_valid), 32'd0);
        check("t5_xfer",     32'(bus.xfer_count), 32'd0);
        check("t5_busy",     32'(bus.busy), 32'd0);

        // Frame AA/F0 held 5 cycles while din toggles
        send_frame(8'hAA, 8'hF0);
        for (int k = 0; k < 5; k++) begin
            bus.din       = 1'(k % 2);
            bus.din_valid = 1'b1;
            tick();
            check("t2_hold_op_a",   32'(bus.op_a), 32'hAA);
            check("t2_hold_op_b",   32'(bus.op_b), 32'hF0);
            check("t2_hold_ready",  32'(bus.din_ready), 32'd0);
            check("t2_hold_valid",  32'(bus.op_valid), 32'd1);
        end
        bus.din_valid = 1'b0;
        bus.op_ready  = 1'b1;
        tick();
        bus.op_ready  = 1'b0;
        check("t2_xfer",      32'(bus.xfer_count), 32'd1);
        check("t2_op_valid",  32'(bus.op_valid), 32'd0);
        check("t2_din_ready", 32'(bus.din_ready), 32'd1);

        // Frame 0F/FF with din_valid on every other cycle
        v = 16'h0FFF;
        for (int k = 0; k < 32; k++) begin
            bus.din_valid = (k % 2 == 0);
            bus.din       = v[15 - k/2];
            tick();
            if (k == 15) check("t3_valid_after_cycle16", 32'(bus.op_valid), 32'd0);
            if (k == 29) check("t3_valid_after_15bits",  32'(bus.op_valid), 32'd0);
        end
        bus.din_valid = 1'b0;
        check("t3_op_valid", 32'(bus.op_valid), 32'd1);
        check("t3_op_a",     32'(bus.op_a), 32'h0F);
        check("t3_op_b",     32'(bus.op_b), 32'hFF);
        bus.op_ready = 1'b1;
        tick();
        bus.op_ready = 1'b0;
        check("t3_xfer", 32'(bus.xfer_count), 32'd2);

        // Abort after 11 accepted bits, together with a valid '1'
        v = 16'h5A3C;
        for (int i = 0; i < 11; i++) begin
            bus.din       = v[15-i];
            bus.din_valid = 1'b1;
            tick();
        end
        bus.din   = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.abort     = 1'b0;
        bus.din_valid = 1'b0;
        check("t4_busy",      32'(bus.busy), 32'd0);
        check("t4_din_ready", 32'(bus.din_ready), 32'd1);
        check("t4_op_valid",  32'(bus.op_valid), 32'd0);
        check("t4_op_a_kept", 32'(bus.op_a), 32'h5A);
        check("t4_op_b_drop", 32'(bus.op_b), 32'hF9);
        tick();
        send_frame(8'h55, 8'h0F);
        check("t4_new_op_a",  32'(bus.op_a), 32'h55);
        check("t4_new_op_b",  32'(bus.op_b), 32'h0F);
        check("t4_new_valid", 32'(bus.op_valid), 32'd1);
        bus.op_ready = 1'b1;
        tick();
        bus.op_ready = 1'b0;
        check("t4_xfer", 32'(bus.xfer_count), 32'd3);

        // 256 back-to-back frames, op_ready tied high
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.op_ready = 1'b1;
        for (int f = 0; f < 256; f++) begin
            send_frame(8'(f), 8'(~f));
            tick();
            if (f == 254) check("t6_xfer_255", 32'(bus.xfer_count), 32'd255);
            if (f == 255) check("t6_xfer_wrap", 32'(bus.xfer_count), 32'd0);
        end
        bus.op_ready = 1'b0;
        check("t6_last_op_a", 32'(bus.op_a), 32'hFF);
        check("t6_last_op_b", 32'(bus.op_b), 32'h00);

        // LSB-first instance: 1,0,0,0,0,0,0,0 then eight zeros
        for (int i = 0; i < 16; i++) begin
            bus2.din       = (i == 0);
            bus2.din_valid = 1'b1;
            tick();
        end
        bus2.din_valid = 1'b0;
        check("t7_lsb_op_a",      32'(bus2.op_a), 32'h01);
        check("t7_lsb_op_b",      32'(bus2.op_b), 32'h00);
        check("t7_lsb_op_valid",  32'(bus2.op_valid), 32'd1);
        check("t7_lsb_din_ready", 32'(bus2.din_ready), 32'd0);
        check("t7_lsb_busy",      32'(bus2.busy), 32'd0);
        check("t7_lsb_xfer",      32'(bus2.xfer_count), 32'd0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_loader8.md
Name: operand_loader8

Overview:
- Upstream feeder for the 8-bit AND stage (and8_gate).
- Deserialises a 1-bit input stream into two WIDTH-bit operands, A then B, and presents them on in1/in2-compatible outputs with a valid/ready handshake.
- Holds both operands stable until the consumer accepts them, and counts completed transfers.

Parameters:
- WIDTH, 8: operand width in bits; also the bit count per operand.
- MSB_FIRST, 1: 1 = first serial bit lands in operand bit WIDTH-1; 0 = first bit lands in bit 0.
- CNT_W, 8: width of the transfer counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- din  input  1  serial data bit.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  loader accepts a bit this cycle.
- abort  input  1  synchronous discard of any partial frame.
- op_a  output  WIDTH  operand A; drives in1 of the AND stage.
- op_b  output  WIDTH  operand B; drives in2 of the AND stage.
- op_valid  output  1  op_a/op_b form a complete pair.
- op_ready  input  1  consumer accepts the pair.
- busy  output  1  partial frame in progress (at least one bit accepted, pair not yet complete).
- xfer_count  output  CNT_W  number of completed handshakes, modulo 2^CNT_W.

Behaviour:
- States: LOAD_A, LOAD_B, HOLD. A bit counter runs 0..WIDTH-1.
- Reset (rst_n=0 at an edge):
  - state=LOAD_A, bit counter=0.
  - op_a=0, op_b=0, op_valid=0, busy=0, xfer_count=0.
  - din_ready becomes 1 in the first cycle after reset.
  - Reset overrides every other input, including mid-frame and during HOLD.
- Bit acceptance: a bit is accepted when din_valid & din_ready at the edge.
  - din_ready = 1 in LOAD_A and LOAD_B; 0 in HOLD.
- LOAD_A:
  - Each accepted bit shifts into op_a in the direction set by MSB_FIRST; the counter increments.
  - On the WIDTH-th accepted bit: counter wraps to 0, next state is LOAD_B.
- LOAD_B:
  - Same shifting rule, into op_b.
  - On the WIDTH-th accepted bit: next state is HOLD and op_valid=1 from the following cycle.
  - Latency: op_valid rises one cycle after the edge that accepts bit 2*WIDTH.
- HOLD:
  - op_a, op_b and op_valid are held constant.
  - din is ignored.
  - On an edge with op_ready=1: xfer_count increments (wraps from 2^CNT_W-1 to 0), op_valid=0, next state is LOAD_A.
  - op_a/op_b keep their last values until they are overwritten by shifting.
  - If op_ready is already high on the first HOLD cycle, the handshake completes on that edge; minimum HOLD residency is 1 cycle.
- busy = 1 in LOAD_A with counter != 0, and in LOAD_B; 0 otherwise.
- abort=1 at an edge:
  - Next state is LOAD_A, counter=0, op_valid=0.
  - op_a/op_b are not cleared.
  - Abort takes priority over a simultaneous accepted bit; that bit is dropped.
  - In HOLD with op_ready=1 on the same edge, the transfer still counts (the consumer has sampled the data), then the loader goes to LOAD_A.
- Gaps in din_valid: stall shifting only; there is no timeout.
- op_valid never deasserts without op_ready, abort or reset.

Decomposition:
- Shared package operand_loader_pkg:
  - State encoding localparams: ST_LOAD_A=2'd0, ST_LOAD_B=2'd1, ST_HOLD=2'd2.
  - Default WIDTH and CNT_W constants.
- Sub-module shift_reg_w:
  - WIDTH-bit, enable-controlled, direction-parameterised shift register with synchronous active-low reset.
  - Instantiated twice, for A and B.
- FSM, bit counter and transfer counter live in the top module.

Test Plan:
- Reset then serial 00110011 followed by 11001100, MSB_FIRST=1, din_valid held high:
  - op_valid=1 exactly 1 cycle after the 16th bit.
  - op_a=8'h33, op_b=8'hCC; the AND stage output is 8'h00.
  - busy=1 from cycle 2 to cycle 16.
- Load 10101010 / 11110000 with op_ready held low for 5 cycles while din toggles:
  - op_a=8'hAA and op_b=8'hF0 stay stable; din_ready=0 throughout.
  - op_ready=1 gives xfer_count=1, op_valid=0 and din_ready=1 on the next cycle.
- din_valid toggled every other cycle for a 16-bit frame 8'h0F/8'hFF:
  - Correct operands; op_valid arrives after the 16th accepted bit, not after cycle 16.
- Abort after 11 accepted bits, together with a valid bit:
  - The bit is dropped, busy=0, state is LOAD_A.
  - A following full frame 8'h55/8'h0F loads correctly.
- rst_n=0 during HOLD with op_ready=1:
  - All outputs return to reset values; xfer_count=0 (not 1).
- 256 back-to-back frames with op_ready tied high:
  - xfer_count wraps 255 to 0.
  - With MSB_FIRST=0, serial 1,0,0,0,0,0,0,0 yields op_a=8'h01.
